// File: rtl/light_dance_ctrl.sv
// Light-dance register controller.
// On a start request it loads one of four seed patterns into an external
// shift register. It then issues a programmable number of shift steps at a
// programmable rate, and finally pulses done. Every output is a flop, so
// the next-cycle values are computed as <sig>_d and captured into <sig>_q.
module light_dance_ctrl #(
    parameter logic [7:0] SEED0 = 8'h81,
    parameter logic [7:0] SEED1 = 8'hAA,
    parameter logic [7:0] SEED2 = 8'h0F,
    parameter logic [7:0] SEED3 = 8'h01
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] pat_sel,
    input  logic [7:0] steps,
    input  logic [7:0] speed,
    input  logic       din_mode,
    output logic       load,
    output logic [7:0] pdata,
    output logic       shift_en,
    output logic       din,
    output logic       busy,
    output logic       done,
    output logic [7:0] step_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] pat_sel_q, pat_sel_d;
    logic [7:0] steps_q, steps_d;
    logic [7:0] speed_q, speed_d;
    logic       din_mode_q, din_mode_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] step_cnt_q, step_cnt_d;
    logic       load_q, load_d;
    logic [7:0] pdata_q, pdata_d;
    logic       shift_en_q, shift_en_d;
    logic       din_q, din_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       step_s;

    // Seed pattern for a given selector.
    function automatic logic [7:0] seed_of(input logic [1:0] sel);
        logic [7:0] r;
        case (sel)
            2'd0:    r = SEED0;
            2'd1:    r = SEED1;
            2'd2:    r = SEED2;
            2'd3:    r = SEED3;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Next-state and next-output computation for the coming cycle.
    always_comb begin
        state_d    = state_q;
        pat_sel_d  = pat_sel_q;
        steps_d    = steps_q;
        speed_d    = speed_q;
        din_mode_d = din_mode_q;
        presc_d    = presc_q;
        step_cnt_d = step_cnt_q;
        load_d     = 1'b0;
        pdata_d    = 8'h00;
        shift_en_d = 1'b0;
        din_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        step_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    pat_sel_d  = pat_sel;
                    steps_d    = steps;
                    speed_d    = speed;
                    din_mode_d = din_mode;
                    presc_d    = 8'd0;
                    step_cnt_d = 8'd0;
                    load_d     = 1'b1;
                    pdata_d    = seed_of(pat_sel);
                    busy_d     = 1'b1;
                    state_d    = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (steps_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    // The first RUN cycle is prescaler phase 0.
                    presc_d = 8'd0;
                    busy_d  = 1'b1;
                    step_s  = (speed_q == 8'd0);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // Stop wins over a step that would land in the next cycle.
                    state_d = S_IDLE;
                end else if (shift_en_q && (step_cnt_q == steps_q)) begin
                    // The final step was issued in this cycle.
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    presc_d = (presc_q == speed_q) ? 8'd0 : (presc_q + 8'd1);
                    busy_d  = 1'b1;
                    step_s  = ((presc_q == speed_q) ? 8'd0 : (presc_q + 8'd1)) == speed_q;
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A step issues shift_en with the pre-increment count parity on din.
        if (step_s) begin
            shift_en_d = 1'b1;
            din_d      = din_mode_q & step_cnt_q[0];
            step_cnt_d = step_cnt_q + 8'd1;
        end else begin
            shift_en_d = 1'b0;
        end
    end

    // State, captured run parameters and registered outputs.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= S_IDLE;
            pat_sel_q  <= 2'd0;
            steps_q    <= 8'd0;
            speed_q    <= 8'd0;
            din_mode_q <= 1'b0;
            presc_q    <= 8'd0;
            step_cnt_q <= 8'd0;
            load_q     <= 1'b0;
            pdata_q    <= 8'h00;
            shift_en_q <= 1'b0;
            din_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_sel_q  <= pat_sel_d;
            steps_q    <= steps_d;
            speed_q    <= speed_d;
            din_mode_q <= din_mode_d;
            presc_q    <= presc_d;
            step_cnt_q <= step_cnt_d;
            load_q     <= load_d;
            pdata_q    <= pdata_d;
            shift_en_q <= shift_en_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign load     = load_q;
    assign pdata    = pdata_q;
    assign shift_en = shift_en_q;
    assign din      = din_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_light_dance_ctrl.sv
// Testbench for light_dance_ctrl.
// The reference model describes a run by cycle offset from the load cycle:
// the shift at step k falls on offset k*(speed+1), done falls one cycle
// after the last shift, and a stop leaves the block idle on the next cycle.
module tb_light_dance_ctrl;

    logic       clk = 1'b0;
    logic       arst;
    logic       start, stop, din_mode;
    logic [1:0] pat_sel;
    logic [7:0] steps, speed;
    logic       load, shift_en, din, busy, done;
    logic [7:0] pdata, step_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seeds [4];

    typedef struct {
        string      name;
        logic [1:0] ps;
        logic [7:0] st;
        logic [7:0] sp;
        logic       dm;
        int         stop_after;
        bit         noisy;
        logic [7:0] e_pdata;
        int         e_busy;
        int         e_shifts;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs [9];

    light_dance_ctrl dut (
        .clk      (clk),
        .arst     (arst),
        .start    (start),
        .stop     (stop),
        .pat_sel  (pat_sel),
        .steps    (steps),
        .speed    (speed),
        .din_mode (din_mode),
        .load     (load),
        .pdata    (pdata),
        .shift_en (shift_en),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " load"},     32'(load),     32'd0);
        chk({tag, " pdata"},    32'(pdata),    32'd0);
        chk({tag, " shift_en"}, 32'(shift_en), 32'd0);
        chk({tag, " din"},      32'(din),      32'd0);
        chk({tag, " busy"},     32'(busy),     32'd0);
        chk({tag, " done"},     32'(done),     32'd0);
        chk({tag, " step_cnt"}, 32'(step_cnt), 32'd0);
    endtask

    // Runs one transaction from IDLE and checks every cycle against the model.
    task automatic do_run(input logic [1:0] ps, input logic [7:0] st, input logic [7:0] sp,
                          input logic dm, input int stop_after, input bit noisy,
                          output int busy_n, output int shift_n,
                          output logic [7:0] pdata_seen, output logic [7:0] final_cnt);
        int per, run_len, c_stop, last, k;
        logic e_busy, e_load, e_shift, e_din, e_done;
        logic [7:0] e_pdata, e_cnt;
        per     = int'(sp) + 1;
        run_len = (st == 8'd0) ? 1 : int'(st) * per + 1;
        c_stop  = (stop_after >= 0) ? stop_after * per : -1;
        last    = (c_stop >= 0) ? c_stop + 2 : run_len + 1;
        busy_n = 0; shift_n = 0; pdata_seen = 8'h00; final_cnt = 8'h00;
        pat_sel = ps; steps = st; speed = sp; din_mode = dm;
        start = 1'b1; stop = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c <= last; c++) begin
            stop = (c == c_stop);
            if (noisy && ((c_stop >= 0) ? (c <= c_stop) : (c <= run_len))) begin
                start    = 1'($urandom_range(0, 1));
                pat_sel  = 2'($urandom);
                steps    = 8'($urandom);
                speed    = 8'($urandom);
                din_mode = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k = c / per;
            if ((c_stop < 0 || c <= c_stop) && c < run_len) begin
                e_busy  = 1'b1;
                e_load  = (c == 0);
                e_pdata = (c == 0) ? seeds[ps] : 8'h00;
                e_shift = (c >= 1) && (c % per == 0);
                e_din   = e_shift && dm && (((k - 1) % 2) == 1);
                e_done  = 1'b0;
                e_cnt   = 8'(k);
            end else if (c_stop < 0 && c == run_len) begin
                e_busy = 1'b0; e_load = 1'b0; e_pdata = 8'h00; e_shift = 1'b0;
                e_din = 1'b0; e_done = 1'b1; e_cnt = st;
            end else begin
                e_busy = 1'b0; e_load = 1'b0; e_pdata = 8'h00; e_shift = 1'b0;
                e_din = 1'b0; e_done = 1'b0;
                e_cnt = (c_stop >= 0) ? 8'(stop_after) : st;
            end
            chk("run busy",     32'(busy),     32'(e_busy));
            chk("run load",     32'(load),     32'(e_load));
            chk("run pdata",    32'(pdata),    32'(e_pdata));
            chk("run shift_en", 32'(shift_en), 32'(e_shift));
            chk("run din",      32'(din),      32'(e_din));
            chk("run done",     32'(done),     32'(e_done));
            chk("run step_cnt", 32'(step_cnt), 32'(e_cnt));
            busy_n  += int'(busy);
            shift_n += int'(shift_en);
            if (load) pdata_seen = pdata;
            final_cnt = step_cnt;
            @(posedge clk); #1;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        int bn, sn, sa;
        logic [7:0] pd, fc, rst, rsp;
        logic [1:0] rps;
        logic rdm;

        seeds[0] = 8'h81; seeds[1] = 8'hAA; seeds[2] = 8'h0F; seeds[3] = 8'h01;
        //          name           ps    st      sp      dm    stop nz  pdata  busy shifts cnt
        vecs[0] = '{"basic_aa",    2'd1, 8'd3,   8'd0,   1'b1, -1, 1'b0, 8'hAA, 4,   3,   8'd3};
        vecs[1] = '{"spacing4",    2'd0, 8'd2,   8'd3,   1'b0, -1, 1'b0, 8'h81, 9,   2,   8'd2};
        vecs[2] = '{"zero_steps",  2'd3, 8'd0,   8'd5,   1'b1, -1, 1'b0, 8'h01, 1,   0,   8'd0};
        vecs[3] = '{"stop_after4", 2'd2, 8'd10,  8'd1,   1'b1, 4,  1'b0, 8'h0F, 9,   4,   8'd4};
        vecs[4] = '{"steps255",    2'd0, 8'd255, 8'd0,   1'b1, -1, 1'b0, 8'h81, 256, 255, 8'd255};
        vecs[5] = '{"speed255",    2'd1, 8'd2,   8'd255, 1'b1, -1, 1'b0, 8'hAA, 513, 2,   8'd2};
        vecs[6] = '{"stop_load",   2'd2, 8'd4,   8'd2,   1'b0, 0,  1'b0, 8'h0F, 1,   0,   8'd0};
        vecs[7] = '{"stop_wins",   2'd3, 8'd5,   8'd0,   1'b1, 2,  1'b0, 8'h01, 3,   2,   8'd2};
        vecs[8] = '{"restart_ign", 2'd1, 8'd6,   8'd2,   1'b1, -1, 1'b1, 8'hAA, 19,  6,   8'd6};

        arst = 1'b0; start = 1'b0; stop = 1'b0; pat_sel = 2'd0;
        steps = 8'd0; speed = 8'd0; din_mode = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge clk); arst = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // start and stop together in IDLE must not launch a run
        start = 1'b1; stop = 1'b1; steps = 8'd2;
        repeat (3) begin
            @(negedge clk);
            chk("start_stop busy", 32'(busy), 32'd0);
            chk("start_stop load", 32'(load), 32'd0);
        end
        start = 1'b0; stop = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_run(vecs[i].ps, vecs[i].st, vecs[i].sp, vecs[i].dm, vecs[i].stop_after,
                   vecs[i].noisy, bn, sn, pd, fc);
            chk({vecs[i].name, " pdata"},  32'(pd), 32'(vecs[i].e_pdata));
            chk({vecs[i].name, " busy_n"}, 32'(bn), 32'(vecs[i].e_busy));
            chk({vecs[i].name, " shifts"}, 32'(sn), 32'(vecs[i].e_shifts));
            chk({vecs[i].name, " cnt"},    32'(fc), 32'(vecs[i].e_cnt));
        end

        // asynchronous reset in the middle of a run
        pat_sel = 2'd1; steps = 8'd10; speed = 8'd0; din_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst step_cnt", 32'(step_cnt), 32'd5);
        #1 arst = 1'b0;
        #1;
        chk_all_zero("mid_run_reset");
        @(negedge clk); arst = 1'b1;
        do_run(2'd2, 8'd10, 8'd0, 1'b1, -1, 1'b0, bn, sn, pd, fc);
        chk("after_rst shifts", 32'(sn), 32'd10);
        chk("after_rst cnt",    32'(fc), 32'd10);

        // randomized runs against the model
        for (int r = 0; r < 25; r++) begin
            rps = 2'($urandom);
            rst = 8'($urandom_range(0, 12));
            rsp = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
            rdm = 1'($urandom);
            sa  = (rst != 8'd0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rst) - 1)) : -1;
            do_run(rps, rst, rsp, rdm, sa, 1'($urandom), bn, sn, pd, fc);
            chk("rand shifts", 32'(sn), (sa >= 0) ? 32'(sa) : 32'(rst));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/light_dance_ctrl.md
LIGHT_DANCE_CTRL -- requirements
Module: light_dance_ctrl

Interface
REQ-001 Parameter: SEED0, 8'h81, seed pattern for pat_sel=0.
REQ-002 Parameter: SEED1, 8'hAA, seed pattern for pat_sel=1.
REQ-003 Parameter: SEED2, 8'h0F, seed pattern for pat_sel=2.
REQ-004 Parameter: SEED3, 8'h01, seed pattern for pat_sel=3.
REQ-005 Port: clk  in  1  single clock; all state updates on its posedge.
REQ-006 Port: arst  in  1  reset, asynchronous, active-low.
REQ-007 Port: start  in  1  run request, sampled every cycle.
REQ-008 Port: stop  in  1  abort request, sampled every cycle.
REQ-009 Port: pat_sel  in  2  seed select.
REQ-010 Port: steps  in  8  number of shift steps per run.
REQ-011 Port: speed  in  8  clock cycles per step minus one.
REQ-012 Port: din_mode  in  1  0 = din constant 0; 1 = din alternates.
REQ-013 Port: load  out  1  parallel-load strobe to light-dance register.
REQ-014 Port: pdata  out  8  seed value presented with load.
REQ-015 Port: shift_en  out  1  one-cycle shift enable to light-dance register.
REQ-016 Port: din  out  1  serial input to light-dance register, valid with shift_en.
REQ-017 Port: busy  out  1  high in LOAD and RUN.
REQ-018 Port: done  out  1  one-cycle completion pulse.
REQ-019 Port: step_cnt  out  8  steps issued in current/last run.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-021 IDLE: start=1 and stop=0 SHALL capture pat_sel, steps, speed, din_mode and go to LOAD next cycle; otherwise stay.
REQ-022 LOAD: load=1 and pdata=SEEDn of captured pat_sel for exactly one cycle; prescaler and step_cnt cleared to 0.
REQ-023 LOAD exit: captured steps=0 -> DONE; else -> RUN.
REQ-024 RUN: 8-bit prescaler counts 0..speed; on prescaler==speed SHALL assert shift_en one cycle, wrap prescaler to 0, increment step_cnt.
REQ-025 Step spacing SHALL be speed+1 cycles; first shift_en SHALL occur speed+1 cycles after load.
REQ-026 speed=0 SHALL give shift_en every cycle of RUN; speed=255 SHALL give every 256 cycles.
REQ-027 din SHALL equal 0 when din_mode=0; when din_mode=1, din SHALL equal step_cnt[0] prior to the increment (0,1,0,1,...); din=0 whenever shift_en=0.
REQ-028 When incremented step_cnt equals captured steps, FSM SHALL go to DONE next cycle; steps=255 yields 255 shifts, no wrap.
REQ-029 DONE: done=1 for one cycle, then IDLE; step_cnt holds final value until next LOAD.
REQ-030 load, shift_en, done SHALL be mutually exclusive; pdata=8'h00 outside LOAD.
REQ-031 stop=1 in LOAD or RUN SHALL return FSM to IDLE next cycle with no done pulse and no further load/shift_en; stop wins over a simultaneous step.
REQ-032 start while busy or in DONE SHALL be ignored; input changes during a run SHALL not affect it.
REQ-033 start and stop both high in IDLE SHALL leave FSM in IDLE.

Reset
REQ-034 arst low SHALL immediately force IDLE, prescaler=0, step_cnt=0, and load, pdata, shift_en, din, busy, done all 0, including mid-run.
REQ-035 After arst release, first start SHALL be honoured on the first clk edge.

Verification
REQ-036 pat_sel=1, steps=3, speed=0, din_mode=1, start pulse -> load=1 with pdata=8'hAA one cycle; shift_en on 3 consecutive cycles with din 0,1,0; done one cycle later; step_cnt=3.
REQ-037 steps=2, speed=3 -> shift_en exactly 4 cycles after load and 4 cycles apart; busy high 9 cycles.
REQ-038 steps=0, pat_sel=3 -> load with pdata=8'h01, then done next cycle, no shift_en, step_cnt=0.
REQ-039 steps=10, speed=1, stop asserted after 4th shift_en -> no more shift_en, no done, busy low next cycle, step_cnt=4.
REQ-040 Second start during RUN -> ignored; run completes with original parameters.
REQ-041 arst low mid-RUN (step_cnt=5) -> all outputs 0 asynchronously; subsequent start runs full sequence from step 0.
